wb_commit_unit: RTL and testbench

Writeback/commit stage that consumes the EX/WB pipeline-register outputs of the CPU. It performs the register-file write, resolves branches and jumps into a single PC redirect, and squashes the younger in-flight instructions after a taken redirect using a flush counter. It sits between the EX/WB register and the register file / PC mux, and drives the flush line back to the earlier pipeline stages.

---
 rtl/wb_commit_unit.sv | 105 ++++++++++
 tb/tb_wb_commit_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
//==============================================================================
// Module   : wb_commit_unit
// Brief    : Writeback/commit stage with register-file write, PC redirect and a
//            counter-based squash of younger in-flight instructions.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_commit_unit #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        branchN,
  input  logic        branchZ,
  input  logic        jump,
  input  logic        jumpMem,
  input  logic        N,
  input  logic        Z,
  input  logic        memToReg,
  input  logic        pcReg,
  input  logic        regWrt,
  input  logic [31:0] alu,
  input  logic [31:0] dataMem,
  input  logic [31:0] adder,
  input  logic [5:0]  rd,
  output logic        rf_we,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic [15:0] retire_count
);

  localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sqCnt;

  logic        w_accept;
  logic        w_taken;
  logic [31:0] w_wdata;
  logic [31:0] w_target;
  logic [2:0]  w_sqNext;

  always_comb begin
    w_accept = in_valid && (r_sqCnt == 3'd0);
    w_taken  = jump | jumpMem | (branchZ & Z) | (branchN & N);
    w_wdata  = memToReg ? dataMem : (pcReg ? adder : alu);
    w_target = jumpMem ? dataMem : alu;
    // Counting down has priority: a taken instruction during squash never reloads.
    w_sqNext = r_sqCnt;
    if (r_sqCnt != 3'd0) begin
      w_sqNext = r_sqCnt - 3'd1;
    end else if (w_accept && w_taken) begin
      w_sqNext = c_FLUSH_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sqCnt      <= 3'd0;
      flush        <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= 6'd0;
      rf_wdata     <= 32'd0;
      pc_redirect  <= 1'b0;
      pc_target    <= 32'd0;
      retire_count <= 16'd0;
    end else begin
      r_sqCnt     <= w_sqNext;
      flush       <= (w_sqNext != 3'd0);
      rf_we       <= w_accept && regWrt;
      pc_redirect <= w_accept && w_taken;

      case (r_state)
        IDLE:    if (w_sqNext != 3'd0) r_state <= SQUASH;
        SQUASH:  if (w_sqNext == 3'd0) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_accept && regWrt) begin
        rf_waddr <= rd;
        rf_wdata <= w_wdata;
      end
      if (w_accept && w_taken) begin
        pc_target <= w_target;
      end
      if (w_accept) begin
        retire_count <= retire_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
//==============================================================================
// Module   : tb_wb_commit_unit
// Brief    : Directed self-checking bench for wb_commit_unit (FLUSH_DEPTH=2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, branchN, branchZ, jump, jumpMem, N, Z;
  logic        memToReg, pcReg, regWrt;
  logic [31:0] alu, dataMem, adder;
  logic [5:0]  rd;
  logic        rf_we, pc_redirect, flush;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata, pc_target;
  logic [15:0] retire_count;

  int total = 0;
  int bad   = 0;

  wb_commit_unit #(.FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .branchN(branchN), .branchZ(branchZ), .jump(jump), .jumpMem(jumpMem),
    .N(N), .Z(Z), .memToReg(memToReg), .pcReg(pcReg), .regWrt(regWrt),
    .alu(alu), .dataMem(dataMem), .adder(adder), .rd(rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_valid = 0; branchN = 0; branchZ = 0; jump = 0; jumpMem = 0;
    N = 0; Z = 0; memToReg = 0; pcReg = 0; regWrt = 0;
    alu = 0; dataMem = 0; adder = 0; rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_we"},     32'(rf_we), 0);
    chk({tag, "_waddr"},  32'(rf_waddr), 0);
    chk({tag, "_wdata"},  rf_wdata, 0);
    chk({tag, "_redir"},  32'(pc_redirect), 0);
    chk({tag, "_target"}, pc_target, 0);
    chk({tag, "_flush"},  32'(flush), 0);
    chk({tag, "_retire"}, 32'(retire_count), 0);
  endtask

  initial begin
    clr();
    rst_n = 0;
    repeat (3) tick();
    chkAllZero("rst");
    rst_n = 1;

    // Taken jump, then asynchronous reset in the middle of the squash window
    in_valid = 1; jump = 1; alu = 32'h80;
    tick();
    chk("j_redir",  32'(pc_redirect), 1);
    chk("j_target", pc_target, 32'h80);
    chk("j_flush",  32'(flush), 1);
    chk("j_retire", 32'(retire_count), 1);
    clr();
    tick();
    chk("j_flush2", 32'(flush), 1);
    #1 rst_n = 0;
    #1 chkAllZero("midrst");
    #1 rst_n = 1;
    in_valid = 1; regWrt = 1; rd = 6'd5; alu = 32'd7;
    tick();
    chk("add_we",     32'(rf_we), 1);
    chk("add_waddr",  32'(rf_waddr), 5);
    chk("add_wdata",  rf_wdata, 7);
    chk("add_retire", 32'(retire_count), 1);
    chk("add_flush",  32'(flush), 0);

    // Writeback mux priority
    clr(); in_valid = 1; regWrt = 1; rd = 6'd3;
    memToReg = 1; pcReg = 1; dataMem = 32'hAA; adder = 32'hBB; alu = 32'hCC;
    tick();
    chk("mux_mem",   rf_wdata, 32'hAA);
    chk("mux_waddr", 32'(rf_waddr), 3);
    memToReg = 0;
    tick();
    chk("mux_pc", rf_wdata, 32'hBB);
    pcReg = 0;
    tick();
    chk("mux_alu",    rf_wdata, 32'hCC);
    chk("mux_we",     32'(rf_we), 1);
    chk("mux_retire", 32'(retire_count), 4);

    // Idle cycle: no write, count and write regs hold
    clr();
    tick();
    chk("idle_we",     32'(rf_we), 0);
    chk("idle_retire", 32'(retire_count), 4);
    chk("idle_wdata",  rf_wdata, 32'hCC);
    chk("idle_waddr",  32'(rf_waddr), 3);

    // Taken branchZ, two squashed writes, third accepted
    in_valid = 1; branchZ = 1; Z = 1; alu = 32'h40;
    tick();
    chk("bz_redir",  32'(pc_redirect), 1);
    chk("bz_target", pc_target, 32'h40);
    chk("bz_flush",  32'(flush), 1);
    chk("bz_we",     32'(rf_we), 0);
    chk("bz_retire", 32'(retire_count), 5);
    clr(); in_valid = 1; regWrt = 1; rd = 6'd10; alu = 32'h11;
    tick();
    chk("sq1_we",     32'(rf_we), 0);
    chk("sq1_redir",  32'(pc_redirect), 0);
    chk("sq1_flush",  32'(flush), 1);
    chk("sq1_retire", 32'(retire_count), 5);
    chk("sq1_target", pc_target, 32'h40);
    rd = 6'd11; alu = 32'h12;
    tick();
    chk("sq2_we",     32'(rf_we), 0);
    chk("sq2_flush",  32'(flush), 0);
    chk("sq2_retire", 32'(retire_count), 5);
    rd = 6'd12; alu = 32'h13;
    tick();
    chk("post_we",     32'(rf_we), 1);
    chk("post_waddr",  32'(rf_waddr), 12);
    chk("post_wdata",  rf_wdata, 32'h13);
    chk("post_retire", 32'(retire_count), 6);

    // Not-taken branchN
    clr(); in_valid = 1; branchN = 1; N = 0; alu = 32'h99;
    tick();
    chk("bn_redir",  32'(pc_redirect), 0);
    chk("bn_flush",  32'(flush), 0);
    chk("bn_target", pc_target, 32'h40);
    chk("bn_retire", 32'(retire_count), 7);

    // rd=0 is writable
    clr(); in_valid = 1; regWrt = 1; rd = 6'd0; alu = 32'h5A;
    tick();
    chk("r0_we",    32'(rf_we), 1);
    chk("r0_waddr", 32'(rf_waddr), 0);
    chk("r0_wdata", rf_wdata, 32'h5A);

    // jumpMem target, then jumps during squash are ignored
    clr(); in_valid = 1; jumpMem = 1; dataMem = 32'h100; alu = 32'h20;
    tick();
    chk("jm_redir",  32'(pc_redirect), 1);
    chk("jm_target", pc_target, 32'h100);
    chk("jm_retire", 32'(retire_count), 9);
    clr(); in_valid = 1; jump = 1; alu = 32'h300;
    tick();
    chk("jsq1_redir",  32'(pc_redirect), 0);
    chk("jsq1_flush",  32'(flush), 1);
    chk("jsq1_target", pc_target, 32'h100);
    tick();
    chk("jsq2_redir", 32'(pc_redirect), 0);
    chk("jsq2_flush", 32'(flush), 0);
    chk("jsq2_retire", 32'(retire_count), 9);

    // Simultaneous write and redirect
    clr(); in_valid = 1; jump = 1; regWrt = 1; pcReg = 1;
    adder = 32'h44; rd = 6'd9; alu = 32'h500;
    tick();
    chk("sim_we",     32'(rf_we), 1);
    chk("sim_redir",  32'(pc_redirect), 1);
    chk("sim_wdata",  rf_wdata, 32'h44);
    chk("sim_waddr",  32'(rf_waddr), 9);
    chk("sim_target", pc_target, 32'h500);
    chk("sim_retire", 32'(retire_count), 10);
    clr();
    tick();
    tick();
    chk("sim_flushend", 32'(flush), 0);

    // Retire counter wrap
    #1 rst_n = 0;
    #1 rst_n = 1;
    clr(); in_valid = 1;
    for (int i = 0; i < 65535; i++) tick();
    chk("wrap_max", 32'(retire_count), 32'hFFFF);
    in_valid = 0;
    tick();
    chk("wrap_hold", 32'(retire_count), 32'hFFFF);
    in_valid = 1;
    tick();
    chk("wrap_zero", 32'(retire_count), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
